mm_iter: RTL and testbench

- Sequential, parametrised Montgomery multiplier. Computes result = x*y*R^-1 mod q, with R = 2^WIDTH.
- Word-serial: consumes DIGIT bits of x per cycle (radix-2^DIGIT interleaved reduction), replacing the single-cycle 3-multiplier datapath.
- Modulus and its Montgomery constant are run-time inputs, so one instance serves several fields.
- Sits between the point-arithmetic controller and the field-op scheduler, with valid/ready on both sides.

---
 rtl/mm_iter_pkg.sv | 16 +
 rtl/mm_digit_step.sv | 26 ++
 rtl/mm_iter.sv | 106 ++++++++++
 tb/tb_mm_iter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_iter_pkg.sv
// Shared types and constants for the word-serial Montgomery multiplier (mm_iter).
package mm_iter_pkg;
    localparam int WIDTH_DEF = 255;
    localparam int DIGIT_DEF = 17;

    // Curve25519 field prime 2^255-19 and (-q^-1) mod 2^17
    localparam logic [254:0] Q_25519        = {255{1'b1}} - 255'd18;
    localparam logic [16:0]  Q_25519_NINV17 = 17'd117275;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } mm_state_t;
endpackage

// File: rtl/mm_digit_step.sv
// One radix-2^DIGIT interleaved Montgomery step: t_next = (t + xi*y + m*q) / 2^DIGIT.
module mm_digit_step import mm_iter_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIGIT = DIGIT_DEF
) (
    input  logic [WIDTH:0]   t,
    input  logic [DIGIT-1:0] xi,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] q,
    input  logic [DIGIT-1:0] q_ninv,
    output logic [WIDTH:0]   t_next
);
    localparam int SW = WIDTH + DIGIT + 2;

    logic [SW-1:0]    s;
    logic [SW-1:0]    sum;
    logic [DIGIT-1:0] m;

    always_comb begin
        s      = SW'(t) + SW'(xi) * SW'(y);
        // m makes the low DIGIT bits of s + m*q zero, so the shift is exact
        m      = DIGIT'(s[DIGIT-1:0] * q_ninv);
        sum    = s + SW'(m) * SW'(q);
        t_next = (WIDTH+1)'(sum >> DIGIT);
    end
endmodule

// File: rtl/mm_iter.sv
// Word-serial Montgomery multiplier: result = x*y*2^-WIDTH mod q, DIGIT bits of x per cycle.
// Define MM_FINAL_SUB_EN for a fully reduced result; otherwise output is lazily reduced in [0, 2q).
module mm_iter import mm_iter_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIGIT = DIGIT_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic [WIDTH-1:0] i_q,
    input  logic [DIGIT-1:0] i_q_ninv,
    output logic             o_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_result
);
    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int CW         = $clog2(NUM_DIGITS + 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_digit
        $error("mm_iter: WIDTH must be a multiple of DIGIT");
    end

    mm_state_t        state;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH-1:0] q_r;
    logic [DIGIT-1:0] ninv_r;
    logic [WIDTH:0]   t_r;
    logic [WIDTH:0]   t_next;
    logic [CW-1:0]    cnt;

    // x is shifted down each cycle so the current digit is always at the bottom
    mm_digit_step #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_step (
        .t      (t_r),
        .xi     (x_r[DIGIT-1:0]),
        .y      (y_r),
        .q      (q_r),
        .q_ninv (ninv_r),
        .t_next (t_next)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            x_r        <= '0;
            y_r        <= '0;
            q_r        <= '0;
            ninv_r     <= '0;
            t_r        <= '0;
            cnt        <= '0;
            o_valid    <= 1'b0;
            o_in_ready <= 1'b1;
            o_result   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        x_r        <= i_x;
                        y_r        <= i_y;
                        q_r        <= i_q;
                        ninv_r     <= i_q_ninv;
                        t_r        <= '0;
                        cnt        <= '0;
                        o_in_ready <= 1'b0;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    t_r <= t_next;
                    x_r <= x_r >> DIGIT;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(NUM_DIGITS - 1)) begin
`ifdef MM_FINAL_SUB_EN
                        state    <= FINAL;
`else
                        o_result <= t_next[WIDTH-1:0];
                        o_valid  <= 1'b1;
                        state    <= DONE;
`endif
                    end
                end
`ifdef MM_FINAL_SUB_EN
                FINAL: begin
                    if (t_r >= {1'b0, q_r})
                        o_result <= WIDTH'(t_r - {1'b0, q_r});
                    else
                        o_result <= t_r[WIDTH-1:0];
                    o_valid <= 1'b1;
                    state   <= DONE;
                end
`endif
                DONE: begin
                    if (i_out_ready) begin
                        o_valid    <= 1'b0;
                        o_in_ready <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mm_iter.sv
// Scoreboard bench for mm_iter: expected results come from plain big-integer Montgomery math.
module tb_mm_iter;
    import mm_iter_pkg::*;

    localparam int W  = WIDTH_DEF;
    localparam int D  = DIGIT_DEF;
    localparam int ND = W / D;
`ifdef MM_FINAL_SUB_EN
    localparam int LAT = ND + 2;
`else
    localparam int LAT = ND + 1;
`endif

    typedef logic [W-1:0]     word_t;
    typedef logic [2*W+2:0]   wide_t;

    typedef struct {
        word_t exp_lazy;
        word_t exp_mod;
        word_t q;
        int    hs_cyc;
    } exp_t;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b1;
    logic         i_valid = 1'b0;
    logic         o_in_ready;
    word_t        i_x = '0;
    word_t        i_y = '0;
    word_t        i_q = '0;
    logic [D-1:0] i_q_ninv = '0;
    logic         o_valid;
    logic         i_out_ready = 1'b1;
    word_t        o_result;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rdy_mode = 1;   // 0: hold low, 1: hold high, 2: random
    exp_t sb[$];

    mm_iter dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_in_ready  (o_in_ready),
        .i_x         (i_x),
        .i_y         (i_y),
        .i_q         (i_q),
        .i_q_ninv    (i_q_ninv),
        .o_valid     (o_valid),
        .i_out_ready (i_out_ready),
        .o_result    (o_result)
    );

    initial forever #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input bit ok, input word_t act, input word_t req);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // -q^-1 mod 2^W by Newton iteration (precision doubles each step from 3 bits)
    function automatic word_t ninv_full(input word_t q);
        word_t inv;
        inv = q;
        for (int i = 0; i < 8; i++) inv = inv * (word_t'(2) - q * inv);
        return word_t'(0) - inv;
    endfunction

    function automatic word_t rnd_word();
        word_t r;
        r = '0;
        for (int i = 0; i < 8; i++) r = (r << 32) | word_t'($urandom);
        return r;
    endfunction

    function automatic word_t rand_below(input word_t q);
        int sel;
        sel = $urandom_range(0, 15);
        if (sel == 0) return '0;
        if (sel == 1) return q - 1'b1;
        return rnd_word() % q;
    endfunction

    // Called in the posedge+1 phase; holds i_valid until accepted, then scrambles inputs.
    task automatic do_op(input word_t x, input word_t y, input word_t q, input logic [D-1:0] nv);
        int n;
        bit rdy;
        n = 0;
        i_valid = 1'b1; i_x = x; i_y = y; i_q = q; i_q_ninv = nv;
        do begin
            rdy = o_in_ready;
            @(posedge i_clk); #1;
            n++;
        end while (!rdy && n < 300);
        if (!rdy) chk("accept_timeout", 1'b0, word_t'(n), word_t'(300));
        i_valid = 1'b0;
        i_x = rnd_word(); i_y = rnd_word(); i_q = rnd_word(); i_q_ninv = D'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || o_valid) && n < 2000) begin
            @(posedge i_clk); #1;
            n++;
        end
        if (n >= 2000) chk("drain_timeout", 1'b0, word_t'(sb.size()), '0);
    endtask

    task automatic run_rand(input word_t q, input int n);
        word_t nf;
        nf = ninv_full(q);
        for (int i = 0; i < n; i++) do_op(rand_below(q), rand_below(q), q, nf[D-1:0]);
    endtask

    // Output-ready driver
    initial forever begin
        @(posedge i_clk); #1;
        case (rdy_mode)
            0:       i_out_ready = 1'b0;
            1:       i_out_ready = 1'b1;
            default: i_out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: pushes expectations at input handshakes, pops at each new result
    initial begin
        exp_t  e;
        wide_t xy, tf;
        word_t nq, m, rinv, held_res;
        bit    held_v, ok;
        held_v = 1'b0;
        held_res = '0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                sb.delete();
                held_v = 1'b0;
                chk("reset_valid", o_valid == 1'b0, word_t'(o_valid), '0);
                chk("reset_in_ready", o_in_ready == 1'b1, word_t'(o_in_ready), word_t'(1));
                chk("reset_result", o_result == '0, o_result, '0);
            end else begin
                if (o_valid && !held_v) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_valid", 1'b0, o_result, '0);
                    end else begin
                        e = sb.pop_front();
`ifdef MM_FINAL_SUB_EN
                        chk("result", o_result == e.exp_mod, o_result, e.exp_mod);
`else
                        ok = (o_result == e.exp_lazy);
                        if (!e.q[W-1])
                            ok = ok && (o_result % e.q == e.exp_mod) &&
                                 ({1'b0, o_result} < {e.q, 1'b0});
                        chk("result", ok, o_result, e.exp_lazy);
`endif
                        chk("latency", (cyc - e.hs_cyc) == LAT, word_t'(cyc - e.hs_cyc), word_t'(LAT));
                    end
                    held_res = o_result;
                end else if (o_valid && held_v) begin
                    chk("stall_stable", o_result == held_res, o_result, held_res);
                    chk("stall_in_ready", o_in_ready == 1'b0, word_t'(o_in_ready), '0);
                end
                if (i_valid && o_in_ready) begin
                    chk("accept_only_idle", sb.size() == 0 && !o_valid, word_t'(sb.size()), '0);
                    xy   = wide_t'(i_x) * wide_t'(i_y);
                    nq   = ninv_full(i_q);
                    m    = word_t'(xy[W-1:0] * nq);
                    tf   = (xy + wide_t'(m) * wide_t'(i_q)) >> W;
                    rinv = word_t'((wide_t'(nq) * wide_t'(i_q) + wide_t'(1)) >> W);
                    e.exp_lazy = tf[W-1:0];
                    e.exp_mod  = word_t'((xy % wide_t'(i_q)) * wide_t'(rinv) % wide_t'(i_q));
                    e.q        = i_q;
                    e.hs_cyc   = cyc;
                    sb.push_back(e);
                end
                held_v = o_valid && !i_out_ready;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        word_t q2, q3;
        q2 = {W{1'b1}} - word_t'(764);   // 2^255-765
        q3 = {1'b0, {(W-1){1'b1}}} - word_t'(32);  // 2^254-33, in contract for lazy output

        #2 i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Directed: zero, identity, identity at top of range
        do_op(word_t'(0), word_t'(12345), Q_25519, Q_25519_NINV17);
        do_op(word_t'(19), word_t'(5), Q_25519, Q_25519_NINV17);
        do_op(word_t'(19), Q_25519 - 1'b1, Q_25519, Q_25519_NINV17);
        wait_idle();

        // Backpressure: second op must wait for the first result handshake
        rdy_mode = 0;
        do_op(rand_below(Q_25519), rand_below(Q_25519), Q_25519, Q_25519_NINV17);
        fork
            do_op(rand_below(Q_25519), rand_below(Q_25519), Q_25519, Q_25519_NINV17);
            begin
                int n;
                n = 0;
                while (!o_valid && n < 100) begin
                    @(posedge i_clk); #1;
                    n++;
                end
                if (n >= 100) chk("bp_valid_timeout", 1'b0, word_t'(n), word_t'(100));
                repeat (10) @(posedge i_clk);
                #1 rdy_mode = 1;
            end
        join
        wait_idle();

        // Reset in the middle of CALC aborts the op silently
        do_op(rand_below(Q_25519), rand_below(Q_25519), Q_25519, Q_25519_NINV17);
        repeat (7) @(posedge i_clk);
        #1 i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        #1 i_rst_n = 1'b1;
        repeat (25) @(posedge i_clk);
        #1;
        do_op(word_t'(19), word_t'(19), Q_25519, Q_25519_NINV17);
        wait_idle();

        // Random regression over three moduli with random downstream stalls
        rdy_mode = 2;
        run_rand(Q_25519, 700);
        run_rand(q2, 500);
        run_rand(q3, 300);
        rdy_mode = 1;
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
